// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (output start, a, b, input busy, done, diff, borrow_out, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, zero);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first: one full-subtractor cell plus a borrow flip-flop,
// with a start/busy/done handshake and result registers held between operations.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             w_accept;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_work;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_zero;

  logic             w_x, w_y, w_d, w_br_nxt, w_last;
  logic [WIDTH-1:0] w_work_nxt;

  assign w_x        = r_a_sr[0];
  assign w_y        = r_b_sr[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_br_nxt   = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
  assign w_work_nxt = {w_d, r_work[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // start is only honoured outside SHIFT, so operands in flight are never disturbed
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = bus.start;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE: begin
        w_accept = bus.start;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_accept) w_next = S_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_work   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= bus.a;
      r_b_sr <= bus.b;
      r_work <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_work <= w_work_nxt;
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + CW'(1);
      // results publish from the in-flight values so done lines up with them
      if (w_last) begin
        r_diff   <= w_work_nxt;
        r_borrow <= w_br_nxt;
        r_zero   <= (w_work_nxt == '0);
      end
    end
  end

  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow;
  assign bus.zero       = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector table plus hand sequences for the 8-bit subtractor, and an exhaustive 4-bit sweep.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] prev_res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // lat counts edges from the accept edge (inclusive) to the edge that raises done
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int nbusy, output bit stable);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b;
    @(posedge clk);
    lat = 1; nbusy = 0; stable = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) nbusy++;
      if ({if8.diff, if8.borrow_out, if8.zero} !== prev_res) stable = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vt[8];
    int   lat, nb, np, last_c;
    bit   st;

    vt[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
    vt[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1};
    vt[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vt[7] = '{8'h40, 8'h01, 8'h3F, 1'b0, 1'b0};

    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy/done", {if8.busy, if8.done}, 2'b00);
    chk("reset results", {if8.diff, if8.borrow_out, if8.zero}, 10'h0);
    rst_n = 1'b1;
    prev_res = '0;

    for (int i = 0; i < 8; i++) begin
      run8(vt[i].a, vt[i].b, lat, nb, st);
      chk($sformatf("v%0d latency", i), lat, 9);
      chk($sformatf("v%0d busy cycles", i), nb, 8);
      chk($sformatf("v%0d held during op", i), st, 1);
      chk($sformatf("v%0d diff", i), if8.diff, vt[i].diff);
      chk($sformatf("v%0d borrow", i), if8.borrow_out, vt[i].borrow);
      chk($sformatf("v%0d zero", i), if8.zero, vt[i].zero);
      @(negedge clk);
      chk($sformatf("v%0d done width", i), if8.done, 0);
      prev_res = {vt[i].diff, vt[i].borrow, vt[i].zero};
    end

    // start while busy must be ignored
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h35; if8.b = 8'h12;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01;
    @(negedge clk);
    if8.start = 1'b0;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      if (if8.done) begin
        np++;
        chk("busy-start diff", if8.diff, 8'h23);
      end
      @(negedge clk);
    end
    chk("busy-start done pulses", np, 1);
    prev_res = {8'h23, 1'b0, 1'b0};

    // start held high: back-to-back every 9 cycles
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h09; if8.b = 8'h03;
    np = 0; last_c = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if8.done) begin
        if (np > 0) chk("b2b interval", c - last_c, 9);
        chk("b2b diff", {if8.diff, if8.borrow_out, if8.zero}, {8'h06, 1'b0, 1'b0});
        np++;
        last_c = c;
      end
    end
    chk("b2b pulse count", np, 4);
    if8.start = 1'b0;
    repeat (12) @(negedge clk);
    prev_res = {8'h06, 1'b0, 1'b0};

    // async reset in the 4th shift cycle
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h35; if8.b = 8'h12;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", if8.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-op reset outputs",
        {if8.busy, if8.done, if8.diff, if8.borrow_out, if8.zero}, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if8.done || if8.busy) np++;
    end
    chk("no activity after reset", np, 0);
    prev_res = '0;
    run8(8'h40, 8'h01, lat, nb, st);
    chk("post-reset latency", lat, 9);
    chk("post-reset diff", {if8.diff, if8.borrow_out, if8.zero}, {8'h3F, 1'b0, 1'b0});

    // exhaustive 4-bit sweep
    for (int i = 0; i < 256; i++) begin
      logic [3:0] xa, xb, ed;
      int w;
      xa = 4'(i >> 4);
      xb = 4'(i);
      ed = xa - xb;
      @(negedge clk);
      if4.start = 1'b1; if4.a = xa; if4.b = xb;
      @(negedge clk);
      if4.start = 1'b0;
      w = 0;
      while (!if4.done && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("w4 %0h-%0h", xa, xb), {w < 20, if4.diff, if4.borrow_out, if4.zero},
          {1'b1, ed, (xa < xb), (ed == 4'h0)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
